alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Downstream end of the ALU interface; consumes ALU out/flags/set_flags for each issued instruction.
- Holds the architectural flag register (P/Z/N), resolves conditional branches against it, and squashes wrong-path beats after a taken branch.
- Forwards surviving register writes to the register-file writeback port through a 2-entry skid buffer.
- Sits between the execute stage (ALU) and register-file writeback.

Parameters:
DATA_W, 16, ALU result / register width
REG_AW, 4, destination register address width
KILL_SLOTS, 2, number of accepted beats squashed after a taken branch (1..7)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
in_valid  input  1  execute beat valid
in_ready  output  1  stage can accept a beat
alu_out  input  DATA_W  ALU result
alu_flags  input  3  ALU flags: [2]=P, [1]=Z, [0]=N
set_flags  input  1  ALU indicates the opcode updates flags (CMP/CMPR/arith)
wr_en  input  1  beat writes a register
wr_reg  input  REG_AW  destination register
is_branch  input  1  beat is a conditional branch
cond  input  3  branch condition code
br_target  input  DATA_W  branch target address
redirect  output  1  one-cycle pulse: taken branch
redirect_pc  output  DATA_W  target, valid while redirect=1
flags_q  output  3  architectural flag register
wb_valid  output  1  writeback beat valid
wb_ready  input  1  register file accepts the beat
wb_data  output  DATA_W  write data
wb_reg  output  REG_AW  write address

Behaviour:
- Reset (synchronous, active-high): flags_q=3'b000, redirect=0, redirect_pc=0, wb_valid=0, wb_data=0, wb_reg=0, kill counter=0, skid buffer empty, in_ready=1 from the first cycle after reset. Reset mid-operation discards all buffered beats and any pending squash.
- Accept = in_valid & in_ready. No state changes on cycles without an accept, except skid-buffer drain.
- Kill counter kcnt (3 bits). An accepted beat is killed when kcnt!=0. A killed beat decrements kcnt and has no other effect: no flag update, no redirect, no writeback.
- Live accepted beat:
  - If set_flags=1, flags_q <= alu_flags on the next edge.
  - If is_branch=1, evaluate cond against the current flags_q, which reflects every earlier accepted beat. A CMP followed by a branch in the next cycle therefore sees the CMP flags.
  - cond encoding: 000 NE=!Z; 001 EQ=Z; 010 GT=P; 011 LT=N; 100 GE=P|Z; 101 LE=N|Z; 110 never; 111 always.
  - Taken branch: redirect=1 and redirect_pc=br_target in the cycle after accept; redirect is cleared the following cycle unless another taken branch occurs. kcnt <= KILL_SLOTS.
  - A branch beat never writes the register file and never updates flags, regardless of set_flags and wr_en.
  - If wr_en=1 and is_branch=0, push {alu_out, wr_reg} into the skid buffer.
- Skid buffer: 2 entries, FIFO order. Head drives wb_valid/wb_data/wb_reg. Pop when wb_valid & wb_ready.
  - in_ready = (count<2). Registered, so a full buffer with a same-cycle pop still deasserts in_ready for that cycle.
  - Push-to-wb_valid latency is 1 cycle.
  - Simultaneous push and pop keeps the count unchanged.
  - wb_data/wb_reg are held stable while wb_valid=1 and wb_ready=0.
- Beats with wr_en=0 (CMP, branches, killed beats) are accepted even when the buffer is full? No: in_ready gates all beats uniformly.
- Widths: no arithmetic on data. kcnt saturates at 0.

Decomposition:
- alu_pkg (shared with the ALU): opcode localparams (LL, LH, CMP, CMPR, ADD, ADDR, SUB, SUBR, SHL, SHR, AND, NOT, OR, XOR), flag bit indices FLAG_P=2/FLAG_Z=1/FLAG_N=0, and a cond_t enum for the 3-bit condition codes.
- Sub-module: alu_skid_buffer (parameterised width, 2 entries, valid/ready both sides).
- Condition evaluation is a function in alu_pkg.

Test Plan:
- Reset, then ADD beat alu_out=16'hFFFF, wr_en=1, wr_reg=3, wb_ready=1 -> next cycle wb_valid=1, wb_data=FFFF, wb_reg=3; flags_q stays 000 when set_flags=0.
- CMP beat alu_flags=3'b010, set_flags=1, then next cycle EQ branch br_target=16'h0040 -> redirect pulse with redirect_pc=0040; the next 2 accepted ADD beats produce no wb_valid; the 3rd writes.
- NE branch with flags_q=3'b010 -> no redirect, and the following beat writes normally.
- wb_ready=0 with three consecutive writes 1, 2, 3 -> in_ready drops after two accepts; raise wb_ready -> wb_data sequence 1, 2, then 3, order preserved, no loss.
- Taken branch, then rst asserted during the kill window -> after reset kcnt=0, and the first ADD beat writes back.
- Killed beat carrying set_flags=1, alu_flags=3'b001 -> flags_q unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU opcodes, flag indices and branch condition evaluation
package alu_pkg;

  localparam logic [3:0] OP_LL   = 4'd0;
  localparam logic [3:0] OP_LH   = 4'd1;
  localparam logic [3:0] OP_CMP  = 4'd2;
  localparam logic [3:0] OP_CMPR = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_ADDR = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SUBR = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_AND  = 4'd10;
  localparam logic [3:0] OP_NOT  = 4'd11;
  localparam logic [3:0] OP_OR   = 4'd12;
  localparam logic [3:0] OP_XOR  = 4'd13;

  localparam int FLAG_P = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [2:0] {
    COND_NE    = 3'b000,
    COND_EQ    = 3'b001,
    COND_GT    = 3'b010,
    COND_LT    = 3'b011,
    COND_GE    = 3'b100,
    COND_LE    = 3'b101,
    COND_NEVER = 3'b110,
    COND_ALWAYS = 3'b111
  } cond_t;

  function automatic logic cond_taken(input logic [2:0] code, input logic [2:0] flags);
    logic taken;
    taken = 1'b0;
    case (cond_t'(code))
      COND_NE:     taken = !flags[FLAG_Z];
      COND_EQ:     taken = flags[FLAG_Z];
      COND_GT:     taken = flags[FLAG_P];
      COND_LT:     taken = flags[FLAG_N];
      COND_GE:     taken = flags[FLAG_P] | flags[FLAG_Z];
      COND_LE:     taken = flags[FLAG_N] | flags[FLAG_Z];
      COND_NEVER:  taken = 1'b0;
      COND_ALWAYS: taken = 1'b1;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// rtl/alu_result_stage_if.sv - execute beat and register writeback handshake bundle
interface alu_result_stage_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] alu_out;
  logic [2:0]        alu_flags;
  logic              set_flags;
  logic              wr_en;
  logic [REG_AW-1:0] wr_reg;
  logic              is_branch;
  logic [2:0]        cond;
  logic [DATA_W-1:0] br_target;
  logic              wb_valid;
  logic              wb_ready;
  logic [DATA_W-1:0] wb_data;
  logic [REG_AW-1:0] wb_reg;

  modport master (
    output in_valid, alu_out, alu_flags, set_flags, wr_en, wr_reg,
           is_branch, cond, br_target, wb_ready,
    input  in_ready, wb_valid, wb_data, wb_reg
  );

  modport slave (
    input  in_valid, alu_out, alu_flags, set_flags, wr_en, wr_reg,
           is_branch, cond, br_target, wb_ready,
    output in_ready, wb_valid, wb_data, wb_reg
  );
endinterface

// File: rtl/alu_skid_buffer.sv
// rtl/alu_skid_buffer.sv - two-entry FIFO skid buffer with registered ready
module alu_skid_buffer #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_tvalid,
  output logic         s_tready,
  input  logic [W-1:0] s_tdata,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic [W-1:0] m_tdata
);
  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic [1:0]   count_q;
  logic         push;
  logic         pop;

  assign push     = s_tvalid & s_tready;
  assign pop      = m_tvalid & m_tready;
  assign s_tready = (count_q != 2'd2);
  assign m_tvalid = (count_q != 2'd0);
  assign m_tdata  = head_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= s_tdata;
          else                 tail_q <= s_tdata;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          // push only happens below full, so count is 1 here
          if (count_q == 2'd1) begin
            head_q <= s_tdata;
          end else begin
            head_q <= tail_q;
            tail_q <= s_tdata;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - flag register, branch resolve/squash and writeback skid
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int REG_AW     = 4,
  parameter int KILL_SLOTS = 2
) (
  input  logic              clk,
  input  logic              rst,
  alu_result_stage_if.slave bus,
  output logic              redirect,
  output logic [DATA_W-1:0] redirect_pc,
  output logic [2:0]        flags_q
);
  logic [2:0] kcnt;
  logic       accept;
  logic       live;
  logic       push_valid;
  logic       push_ready;
  logic [REG_AW+DATA_W-1:0] head_data;

  assign accept     = bus.in_valid & bus.in_ready;
  assign live       = accept & (kcnt == 3'd0);
  assign push_valid = live & bus.wr_en & ~bus.is_branch;
  assign bus.in_ready = push_ready;
  assign bus.wb_reg   = head_data[REG_AW+DATA_W-1:DATA_W];
  assign bus.wb_data  = head_data[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q     <= 3'b000;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      kcnt        <= 3'd0;
    end else begin
      redirect <= 1'b0;
      if (accept) begin
        if (kcnt != 3'd0) begin
          kcnt <= kcnt - 3'd1;
        end else if (bus.is_branch) begin
          // flags_q already includes every earlier accepted beat
          if (cond_taken(bus.cond, flags_q)) begin
            redirect    <= 1'b1;
            redirect_pc <= bus.br_target;
            kcnt        <= 3'(KILL_SLOTS);
          end
        end else if (bus.set_flags) begin
          flags_q <= bus.alu_flags;
        end
      end
    end
  end

  alu_skid_buffer #(.W(REG_AW + DATA_W)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .s_tvalid (push_valid),
    .s_tready (push_ready),
    .s_tdata  ({bus.wr_reg, bus.alu_out}),
    .m_tvalid (bus.wb_valid),
    .m_tready (bus.wb_ready),
    .m_tdata  (head_data)
  );
endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - randomized and directed check against a queue-based model
module tb_alu_result_stage;
  localparam int DATA_W = 16;
  localparam int REG_AW = 4;
  localparam int KILL   = 2;

  logic clk = 1'b0;
  logic rst;
  logic redirect;
  logic [DATA_W-1:0] redirect_pc;
  logic [2:0] flags_q;

  int n_tests = 0;
  int n_fail  = 0;

  alu_result_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

  alu_result_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .KILL_SLOTS(KILL)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .flags_q     (flags_q)
  );

  always #5 clk = ~clk;

  // reference state
  logic [2:0]  m_flags;
  int          m_kcnt;
  logic        m_redirect;
  logic [15:0] m_pc;
  logic [19:0] m_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic bit ref_taken(input logic [2:0] c, input logic [2:0] f);
    bit p, z, n;
    p = f[2]; z = f[1]; n = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return p;
      3'd3: return n;
      3'd4: return p || z;
      3'd5: return n || z;
      3'd6: return 0;
      default: return 1;
    endcase
  endfunction

  task automatic tick();
    bit acc;
    if (rst) begin
      m_flags = 3'b000; m_kcnt = 0; m_redirect = 0; m_pc = 16'h0; m_q.delete();
    end else begin
      acc = bus.in_valid && (m_q.size() < 2);
      m_redirect = 0;
      if (m_q.size() > 0 && bus.wb_ready) void'(m_q.pop_front());
      if (acc) begin
        if (m_kcnt > 0) m_kcnt--;
        else if (bus.is_branch) begin
          if (ref_taken(bus.cond, m_flags)) begin
            m_redirect = 1; m_pc = bus.br_target; m_kcnt = KILL;
          end
        end else begin
          if (bus.set_flags) m_flags = bus.alu_flags;
          if (bus.wr_en) m_q.push_back({bus.wr_reg, bus.alu_out});
        end
      end
    end
    @(posedge clk);
    #1;
    check("in_ready", 32'(bus.in_ready), 32'(m_q.size() < 2));
    check("wb_valid", 32'(bus.wb_valid), 32'(m_q.size() > 0));
    check("flags_q", 32'(flags_q), 32'(m_flags));
    check("redirect", 32'(redirect), 32'(m_redirect));
    check("redirect_pc", 32'(redirect_pc), 32'(m_pc));
    if (m_q.size() > 0) begin
      check("wb_data", 32'(bus.wb_data), 32'(m_q[0][15:0]));
      check("wb_reg", 32'(bus.wb_reg), 32'(m_q[0][19:16]));
    end
  endtask

  task automatic beat(input logic v, input logic [15:0] out, input logic [2:0] fl,
                      input logic sf, input logic we, input logic [3:0] rg,
                      input logic br, input logic [2:0] cd, input logic [15:0] tgt);
    bus.in_valid = v; bus.alu_out = out; bus.alu_flags = fl; bus.set_flags = sf;
    bus.wr_en = we; bus.wr_reg = rg; bus.is_branch = br; bus.cond = cd; bus.br_target = tgt;
  endtask

  initial begin
    rst = 1'b1;
    bus.wb_ready = 1'b1;
    beat(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    check("rst_wb_data", 32'(bus.wb_data), 32'h0);
    check("rst_wb_reg", 32'(bus.wb_reg), 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'h1);

    // plain ADD writeback
    beat(1, 16'hFFFF, 3'b101, 0, 1, 4'd3, 0, 0, 0); tick();
    check("add_wb_data", 32'(bus.wb_data), 32'hFFFF);
    check("add_wb_reg", 32'(bus.wb_reg), 32'd3);
    check("add_flags", 32'(flags_q), 32'h0);

    // CMP then taken EQ branch, two squashed beats
    beat(1, 16'h0, 3'b010, 1, 0, 0, 0, 0, 0); tick();
    beat(1, 16'h0, 3'b000, 0, 0, 0, 1, 3'b001, 16'h0040); tick();
    check("eq_redirect", 32'(redirect), 32'h1);
    check("eq_pc", 32'(redirect_pc), 32'h0040);
    beat(1, 16'd1, 0, 0, 1, 4'd1, 0, 0, 0); tick();
    check("kill1_wb", 32'(bus.wb_valid), 32'h0);
    beat(1, 16'd2, 0, 0, 1, 4'd2, 0, 0, 0); tick();
    check("kill2_wb", 32'(bus.wb_valid), 32'h0);
    beat(1, 16'd3, 0, 0, 1, 4'd3, 0, 0, 0); tick();
    check("post_kill_wb", 32'(bus.wb_data), 32'd3);

    // NE not taken with Z set
    beat(1, 16'h0, 0, 0, 0, 0, 1, 3'b000, 16'h0080); tick();
    check("ne_redirect", 32'(redirect), 32'h0);
    beat(1, 16'h1234, 0, 0, 1, 4'd5, 0, 0, 0); tick();
    check("ne_next_wb", 32'(bus.wb_data), 32'h1234);

    // backpressure ordering
    beat(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    bus.wb_ready = 1'b0;
    beat(1, 16'd1, 0, 0, 1, 4'd1, 0, 0, 0); tick();
    beat(1, 16'd2, 0, 0, 1, 4'd2, 0, 0, 0); tick();
    check("full_in_ready", 32'(bus.in_ready), 32'h0);
    beat(1, 16'd3, 0, 0, 1, 4'd3, 0, 0, 0); tick();
    check("stall_head", 32'(bus.wb_data), 32'd1);
    bus.wb_ready = 1'b1; tick();
    check("drain_2", 32'(bus.wb_data), 32'd2);
    tick();
    check("drain_3", 32'(bus.wb_data), 32'd3);
    beat(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();

    // reset inside the kill window
    beat(1, 0, 0, 0, 0, 0, 1, 3'b001, 16'h0100); tick();
    beat(1, 16'd9, 0, 0, 1, 4'd9, 0, 0, 0); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    beat(1, 16'h00AA, 0, 0, 1, 4'd7, 0, 0, 0); tick();
    check("rst_kill_wb_valid", 32'(bus.wb_valid), 32'h1);
    check("rst_kill_wb_data", 32'(bus.wb_data), 32'h00AA);

    // squashed CMP must not touch flags
    beat(1, 0, 0, 0, 0, 0, 1, 3'b111, 16'h0200); tick();
    beat(1, 0, 3'b001, 1, 0, 0, 0, 0, 0); tick();
    check("killed_flags", 32'(flags_q), 32'h0);
    beat(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();

    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      bus.wb_ready = ($urandom_range(0, 3) != 0);
      beat($urandom_range(0, 3) != 0, 16'($urandom), 3'($urandom), 1'($urandom),
           1'($urandom), 4'($urandom), $urandom_range(0, 3) == 0, 3'($urandom),
           16'($urandom));
      tick();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
